// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready input and framed serial output.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             accept;
  logic             next_bit;
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif

  // Bit that leaves the word first, given the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Discard the head bit so the following bit becomes the new head.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // cnt is the number of frame bits still to come after the one on sout,
  // so cnt==0 in SHIFT marks the last-bit cycle where a new word may load.
  assign in_ready = (state == IDLE) || (cnt == '0);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT);

  always_comb begin
    next_bit = head_bit(sreg);
`ifdef PISO_TX_PARITY_EN
    if (cnt == CNT_ONE) next_bit = par;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
      sout_last  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (accept) begin
      // First bit goes straight to the output register; the rest waits in sreg.
      state      <= SHIFT;
      cnt        <= CNT_LOAD;
      sreg       <= shift_one(in_data);
      sout       <= head_bit(in_data);
      sout_valid <= 1'b1;
      sout_first <= 1'b1;
      sout_last  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par        <= ^in_data;
`endif
    end else if ((state == SHIFT) && (cnt != '0)) begin
      cnt        <= cnt - CNT_ONE;
      sreg       <= shift_one(sreg);
      sout       <= next_bit;
      sout_first <= 1'b0;
      sout_last  <= (cnt == CNT_ONE);
    end else begin
      state      <= IDLE;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
      sout_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: LSB-first and MSB-first instances share stimulus and are
// checked against a frame-position reference model.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int FL = 33;
`else
  localparam int FL = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        ready0, sout0, valid0, first0, last0, busy0;
  logic        ready1, sout1, valid1, first1, last1, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready0), .sout(sout0), .sout_valid(valid0),
    .sout_first(first0), .sout_last(last0), .busy(busy0)
  );

  piso_tx #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready1), .sout(sout1), .sout_valid(valid1),
    .sout_first(first1), .sout_last(last1), .busy(busy1)
  );

  // Frame position p: data bits 0..31 in send order, then parity if enabled.
  function automatic logic exp_bit(input logic [31:0] w, input int p, input bit msb);
    if (p >= 32) return ^w;
    return msb ? w[31-p] : w[p];
  endfunction

  // Idle check: {sout,valid,first,last,busy,ready} must be 000001 on both.
  task automatic check_idle(input string name);
    total++;
    if ({sout0, valid0, first0, last0, busy0, ready0} !== 6'b000001) begin
      bad++;
      $display("FAIL %s lsb: got %b want 000001", name,
               {sout0, valid0, first0, last0, busy0, ready0});
    end
    total++;
    if ({sout1, valid1, first1, last1, busy1, ready1} !== 6'b000001) begin
      bad++;
      $display("FAIL %s msb: got %b want 000001", name,
               {sout1, valid1, first1, last1, busy1, ready1});
    end
  endtask

  // Drives words back-to-back with in_valid held high and checks every cycle
  // of the resulting stream. abort_at>0 asserts rst after that frame cycle.
  task automatic run_stream(input logic [31:0] words[$], input string name,
                            input int abort_at);
    int n;
    int k;
    int p;
    logic [5:0] e0, e1;
    n = words.size();
    @(negedge clk);
    check_idle({name, "_pre"});
    in_valid = 1'b1;
    in_data  = words[0];
    for (int c = 1; c <= n*FL + 1; c++) begin
      @(negedge clk);
      if (c <= n*FL) begin
        k  = (c-1) / FL;
        p  = (c-1) % FL;
        e0 = {exp_bit(words[k], p, 1'b0), 1'b1, p == 0, p == FL-1, 1'b1, p == FL-1};
        e1 = {exp_bit(words[k], p, 1'b1), 1'b1, p == 0, p == FL-1, 1'b1, p == FL-1};
      end else begin
        k  = n;
        p  = 0;
        e0 = 6'b000001;
        e1 = 6'b000001;
      end
      total++;
      if ({sout0, valid0, first0, last0, busy0, ready0} !== e0) begin
        bad++;
        $display("FAIL %s lsb cycle %0d: got %b want %b", name, c,
                 {sout0, valid0, first0, last0, busy0, ready0}, e0);
      end
      total++;
      if ({sout1, valid1, first1, last1, busy1, ready1} !== e1) begin
        bad++;
        $display("FAIL %s msb cycle %0d: got %b want %b", name, c,
                 {sout1, valid1, first1, last1, busy1, ready1}, e1);
      end
      if (abort_at > 0 && c == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
        check_idle({name, "_reset"});
        rst = 1'b0;
        return;
      end
      if (c <= n*FL && p == FL-1) begin
        if (k + 1 < n) begin
          in_data = words[k+1];
        end else begin
          in_valid = 1'b0;
          in_data  = $urandom;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("after_reset");
    end
  endtask

  task automatic test_lsb_pattern();
    logic [31:0] q[$];
    q = '{32'h0000_0005};
    run_stream(q, "pattern_5", 0);
  endtask

  task automatic test_msb_pattern();
    logic [31:0] q[$];
    q = '{32'h8000_0001};
    run_stream(q, "pattern_80000001", 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    q = '{32'hFFFF_FFFF, 32'h0000_0000};
    run_stream(q, "back_to_back", 0);
  endtask

  task automatic test_parity();
    logic [31:0] q[$];
    q = '{32'h0000_0007};
    run_stream(q, "parity_7", 0);
    q = '{32'h0000_0003};
    run_stream(q, "parity_3", 0);
  endtask

  task automatic test_mid_reset();
    logic [31:0] q[$];
    q = '{32'hA5C3_0F96, 32'h1234_5678};
    run_stream(q, "mid_reset", 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("post_abort_idle");
    end
    q = '{32'h0000_0005};
    run_stream(q, "after_abort", 0);
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int len;
    int gap;
    for (int t = 0; t < 8; t++) begin
      q.delete();
      len = $urandom_range(3, 1);
      for (int i = 0; i < len; i++) q.push_back($urandom);
      run_stream(q, "random", 0);
      gap = $urandom_range(3, 0);
      for (int i = 0; i < gap; i++) begin
        in_data = $urandom;
        @(negedge clk);
        check_idle("random_gap");
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_pattern();
    test_msb_pattern();
    test_back_to_back();
    test_parity();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
